// File: rtl/uart_pkg.sv
// Shared constants and state type for the APB UART peripheral.
package uart_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_TXDATA = 2'd2;
  localparam logic [1:0] ADDR_RXDATA = 2'd3;

  localparam int ST_TX_BUSY      = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_VALID     = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_RX_FRAME_ERR = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: rx synchronizer, 16x oversampled frame FSM, byte/frame-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_rx_en,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  uart_state_e r_state;
  uart_state_e w_next;
  logic [3:0]  r_tcnt;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        w_fall;
  logic        w_mid;
  logic        w_end;

  assign w_fall = r_prev & ~r_sync2;
  assign w_mid  = i_tick && (r_tcnt == MID_TICK);
  assign w_end  = i_tick && (r_tcnt == LAST_TICK);
  assign o_byte = r_shift;

  always_comb begin
    w_next       = r_state;
    o_byte_valid = 1'b0;
    o_frame_err  = 1'b0;
    if (!i_rx_en) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (w_fall) w_next = START;
        // A line that is high again at mid start bit was a glitch.
        START: if (w_mid) w_next = r_sync2 ? IDLE : DATA;
        DATA:  if (w_end && (r_bitcnt == 3'd7)) w_next = STOP;
        STOP: begin
          if (w_end) begin
            w_next       = IDLE;
            o_byte_valid = r_sync2;
            o_frame_err  = ~r_sync2;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_prev   <= 1'b0;
      r_state  <= IDLE;
      r_tcnt   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_state <= w_next;
      // Realign the tick count at mid start bit so data samples land mid-bit.
      if ((r_state == IDLE) || ((r_state == START) && w_mid)) begin
        r_tcnt   <= '0;
        r_bitcnt <= '0;
      end else if (i_tick) begin
        r_tcnt <= r_tcnt + 4'd1;
      end
      if ((r_state == DATA) && w_end) begin
        r_shift  <= {r_sync2, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/uart_periph.sv
// APB slave UART (8N1, LSB first): register file, tick generator, TX path, RX buffer.
module uart_periph
  import uart_pkg::*;
#(
  parameter int TICK_DIV   = 651,
  parameter int OVERSAMPLE = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx,
  input  logic        rx
);

  localparam int         TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic          r_pready;
  logic [31:0]   r_prdata;
  logic [31:0]   w_rdata;
  logic [1:0]    w_addr;
  logic          w_setup_done;
  logic          w_commit;
  logic          w_wr;
  logic          w_pop;
  logic          w_w1c;
  logic          r_tx_en;
  logic          r_rx_en;
  logic [7:0]    r_tx_hold;
  logic          r_tx_full;
  uart_state_e   r_tx_state;
  uart_state_e   w_tx_next;
  logic          w_tx_load;
  logic          w_tx_bit_end;
  logic [9:0]    r_tx_shift;
  logic [3:0]    r_tx_tcnt;
  logic [2:0]    r_tx_bitcnt;
  logic [7:0]    r_rx_buf;
  logic          r_rx_valid;
  logic          r_rx_ovr;
  logic          r_rx_ferr;
  logic          w_rx_byte_valid;
  logic [7:0]    w_rx_byte;
  logic          w_rx_frame_err;
  logic          w_unused;

  assign w_unused = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:8]};

  assign w_tick       = (r_tick_cnt == TICK_MAX);
  assign w_addr       = PADDR[3:2];
  assign w_setup_done = PSEL & PENABLE & ~r_pready;
  assign w_commit     = PSEL & PENABLE & r_pready;
  assign w_wr         = w_commit & PWRITE;
  assign w_pop        = w_commit & ~PWRITE & (w_addr == ADDR_RXDATA);
  assign w_w1c        = w_wr & (w_addr == ADDR_STATUS);
  assign w_tx_bit_end = w_tick && (r_tx_tcnt == LAST_TICK);

  assign PREADY = r_pready;
  assign PRDATA = r_prdata;
  assign tx     = r_tx_shift[0];

  uart_rx #(.OVERSAMPLE(OVERSAMPLE)) u_rx (
    .i_clk        (PCLK),
    .i_rst_n      (PRESET),
    .i_tick       (w_tick),
    .i_rx_en      (r_rx_en),
    .i_rx         (rx),
    .o_byte_valid (w_rx_byte_valid),
    .o_byte       (w_rx_byte),
    .o_frame_err  (w_rx_frame_err)
  );

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_CTRL:   w_rdata[1:0] = {r_rx_en, r_tx_en};
      ADDR_STATUS: begin
        w_rdata[ST_TX_BUSY]      = (r_tx_state != IDLE);
        w_rdata[ST_TX_FULL]      = r_tx_full;
        w_rdata[ST_RX_VALID]     = r_rx_valid;
        w_rdata[ST_RX_OVERRUN]   = r_rx_ovr;
        w_rdata[ST_RX_FRAME_ERR] = r_rx_ferr;
      end
      ADDR_RXDATA: w_rdata[7:0] = r_rx_buf;
      default:     w_rdata = '0;
    endcase
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_load = 1'b0;
    case (r_tx_state)
      IDLE: begin
        if (r_tx_en && r_tx_full) begin
          w_tx_next = START;
          w_tx_load = 1'b1;
        end
      end
      START:   if (w_tx_bit_end) w_tx_next = DATA;
      DATA:    if (w_tx_bit_end && (r_tx_bitcnt == 3'd7)) w_tx_next = STOP;
      STOP:    if (w_tx_bit_end) w_tx_next = IDLE;
      default: w_tx_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      r_tick_cnt  <= '0;
      r_pready    <= 1'b0;
      r_prdata    <= '0;
      r_tx_en     <= 1'b0;
      r_rx_en     <= 1'b0;
      r_tx_hold   <= '0;
      r_tx_full   <= 1'b0;
      r_tx_state  <= IDLE;
      r_tx_shift  <= '1;
      r_tx_tcnt   <= '0;
      r_tx_bitcnt <= '0;
      r_rx_buf    <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_rx_ferr   <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;

      r_pready <= w_setup_done;
      r_prdata <= w_setup_done ? w_rdata : '0;

      if (w_wr && (w_addr == ADDR_CTRL)) begin
        r_tx_en <= PWDATA[0];
        r_rx_en <= PWDATA[1];
      end

      if (w_wr && (w_addr == ADDR_TXDATA) && !r_tx_full) begin
        r_tx_hold <= PWDATA[7:0];
        r_tx_full <= 1'b1;
      end else if (w_tx_load) begin
        r_tx_full <= 1'b0;
      end

      // Shifter holds the whole frame {stop, data, start}; ones refill behind it.
      r_tx_state <= w_tx_next;
      if (w_tx_load) begin
        r_tx_shift  <= {1'b1, r_tx_hold, 1'b0};
        r_tx_tcnt   <= '0;
        r_tx_bitcnt <= '0;
      end else if ((r_tx_state != IDLE) && w_tick) begin
        r_tx_tcnt <= r_tx_tcnt + 4'd1;
        if (w_tx_bit_end) begin
          r_tx_shift <= {1'b1, r_tx_shift[9:1]};
          if (r_tx_state == DATA) r_tx_bitcnt <= r_tx_bitcnt + 3'd1;
        end
      end

      // A pop on the delivery edge frees the buffer, so no overrun is flagged.
      if (w_rx_byte_valid && (!r_rx_valid || w_pop)) begin
        r_rx_buf   <= w_rx_byte;
        r_rx_valid <= 1'b1;
      end else if (w_pop) begin
        r_rx_valid <= 1'b0;
      end

      if (w_rx_byte_valid && r_rx_valid && !w_pop) r_rx_ovr <= 1'b1;
      else if (w_w1c && PWDATA[ST_RX_OVERRUN])     r_rx_ovr <= 1'b0;

      if (w_rx_frame_err)                            r_rx_ferr <= 1'b1;
      else if (w_w1c && PWDATA[ST_RX_FRAME_ERR])     r_rx_ferr <= 1'b0;
    end
  end

endmodule

// File: doc/uart_periph.md
Name: uart_periph

Overview:
- APB slave UART peripheral, 8N1, LSB first. Attaches downstream of APB_Master on the next free PSEL/PRDATA/PREADY slot, alongside the RAM and GPIO peripherals.
- Converts CPU load/store bus accesses into serial frames on tx and collects frames from rx into a one-entry receive buffer.
- Contains a TX holding register plus shifter, an RX FSM with 16x oversampling, and a free-running baud tick generator.

Parameters:
- TICK_DIV, 651, PCLK cycles per 16x oversample tick (100 MHz / 9600 baud / 16).
- OVERSAMPLE, 16, ticks per bit period. Fixed at 16; no other value is supported.

Ports:
- PCLK  input  1  clock.
- PRESET  input  1  synchronous reset, active-low.
- PADDR  input  32  byte address; only [3:2] is decoded.
- PWRITE  input  1  1 = write, 0 = read.
- PENABLE  input  1  APB access phase.
- PWDATA  input  32  write data.
- PSEL  input  1  slave select.
- PRDATA  output  32  read data.
- PREADY  output  1  transfer complete.
- tx  output  1  serial out, idles high.
- rx  input  1  serial in, asynchronous.

Behaviour:
- Reset (PRESET=0 at a PCLK edge):
  - tx=1, PRDATA=0, PREADY=0.
  - All registers, flags, FSMs and the tick counter cleared.
  - Reset mid-frame aborts the frame; tx is 1 after that edge.
- APB handshake (one wait state):
  - PREADY is registered. It goes to 1 on the edge after the first PSEL&PENABLE cycle and holds for exactly one cycle.
  - PRDATA is valid while PREADY=1 and is 0 otherwise.
  - Side effects (register write, RX pop, W1C) take effect on the edge where PREADY=1.
- Register map:
  - 0x00 CTRL (RW): [0] TX_EN, [1] RX_EN.
  - 0x04 STATUS: [0] TX_BUSY (RO), [1] TX_FULL (RO), [2] RX_VALID (RO), [3] RX_OVERRUN (sticky, W1C), [4] RX_FRAME_ERR (sticky, W1C).
  - 0x08 TXDATA (WO): reads return 0. A write is accepted only if TX_FULL=0 before the edge; otherwise it is silently dropped.
  - 0x0C RXDATA (RO): returns {24'b0, rx_buf}. The read clears RX_VALID.
- Tick generator: counter runs 0..TICK_DIV-1 and pulses tick for one cycle at TICK_DIV-1. It runs free whenever PRESET=1.
- TX FSM (states IDLE, START, DATA, STOP; each state lasts 16 ticks per bit):
  - IDLE -> START when TX_EN=1 and TX_FULL=1. The holding register moves into the shifter and TX_FULL clears on the same edge.
  - START drives 0; DATA drives bits 0..7; STOP drives 1, then returns to IDLE.
  - TX_BUSY=1 in any state except IDLE.
  - Clearing TX_EN mid-frame lets the current frame finish; no new load occurs.
- RX input path: rx passes through a 2-flop synchronizer before the FSM.
- RX FSM (states IDLE, START, DATA, STOP):
  - IDLE: on a synchronized falling edge with RX_EN=1, go to START.
  - START: sample after 8 ticks. If the line is 0, go to DATA; if 1 (glitch), return to IDLE.
  - DATA: sample every 16 ticks, 8 samples, LSB first.
  - STOP: sample after 16 ticks. If 1, deliver the byte; if 0, set RX_FRAME_ERR and discard the byte. Return to IDLE in both cases.
  - Clearing RX_EN forces IDLE on the next edge and discards any partial byte.
- RX delivery and overrun:
  - Delivering a byte with RX_VALID=0 loads rx_buf and sets RX_VALID.
  - Delivering a byte with RX_VALID=1 sets RX_OVERRUN; the new byte is dropped and the old byte is kept.
  - A delivery and an RXDATA pop on the same edge load the new byte, leave RX_VALID=1, and do not set overrun.
  - A W1C and a new flag event on the same edge leave the flag set.

Decomposition:
- Package uart_pkg:
  - register offset constants (CTRL, STATUS, TXDATA, RXDATA);
  - STATUS bit index constants;
  - typedef enum for uart_state_e (IDLE, START, DATA, STOP), shared by the TX and RX FSMs.
- Sub-module uart_rx: synchronizer, RX FSM and oversample counting. Outputs a byte_valid pulse, byte data and a frame_err pulse. The TX path, tick generator and APB logic stay in uart_periph.

Test Plan (TICK_DIV=4, so one bit = 64 PCLK cycles):
1. Hold PRESET=0 for 2 cycles, then read STATUS -> tx=1, PREADY=0 while idle, PREADY pulses for 1 cycle, PRDATA=0x00000000.
2. Write CTRL=0x3, then TXDATA=0xA5 -> tx shows 0 for 64 cycles, then 1,0,1,0,0,1,0,1 (64 cycles each), then 1. STATUS bit0 reads 1 mid-frame and 0 after.
3. Drive a 0x3C frame on rx -> STATUS=0x4; RXDATA read=0x0000003C; STATUS then reads 0x0.
4. Drive frames 0x11 then 0x22 without reading -> RXDATA=0x11 and STATUS=0xC. Writing STATUS=0x08 then gives STATUS=0x0 after the RXDATA read.
5. Drive a 0x55 frame with stop bit 0 -> STATUS=0x10 and RX_VALID=0. Drive a 3-tick low glitch -> no status change.
6. Write TXDATA 0x01, 0x02, 0x03 back-to-back -> exactly two frames (0x01, 0x02) appear on tx; 0x03 is dropped.
